elastic_pipe_reg: RTL and testbench

Parametrised chain of DEPTH elastic pipeline registers, WIDTH bits each, with valid/ready flow control, global enable and an occupancy count. It sits between DES round stages so that any round boundary can stall without losing or duplicating blocks. It generalises the plain enable register with three additions:

- configurable depth
- back-pressure
- occupancy reporting

---
 rtl/des_pipe_pkg.sv | 19 +
 rtl/elastic_pipe_reg_if.sv | 37 +++
 rtl/elastic_pipe_stage.sv | 70 +++++++
 rtl/elastic_pipe_reg.sv | 108 ++++++++++
 tb/tb_elastic_pipe_reg.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pipe_pkg.sv
// -----------------------------------------------------------------------------
// des_pipe_pkg
// Shared constants and helpers for the DES round pipeline.
//   DES_BLOCK_W : width of one DES block in bits
//   DES_ROUNDS  : number of DES rounds (default elastic chain depth)
//   cnt_w()     : width of an occupancy counter that can hold 0..depth
// -----------------------------------------------------------------------------
package des_pipe_pkg;

   localparam int DES_BLOCK_W = 64;
   localparam int DES_ROUNDS  = 16;

   typedef logic [0:DES_BLOCK_W-1] des_block_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/elastic_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg_if
// Valid/ready bundle around an elastic pipeline chain.
//   in_data/in_valid/in_ready    : upstream side (index 0 of data is MSB)
//   out_data/out_valid/out_ready : downstream side
//   count                        : number of occupied stages
// Modports:
//   master : the environment (drives in_*, out_ready)
//   slave  : the chain (drives in_ready, out_*, count)
// -----------------------------------------------------------------------------
interface elastic_pipe_reg_if
   import des_pipe_pkg::*;
#(
   parameter int WIDTH = DES_BLOCK_W,
   parameter int DEPTH = DES_ROUNDS
);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [0:WIDTH-1] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [0:WIDTH-1] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] count;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, count
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, count
   );

endinterface

// File: rtl/elastic_pipe_stage.sv
// -----------------------------------------------------------------------------
// elastic_pipe_stage
// One elastic register slot: a valid bit plus WIDTH data bits.
// Optional feature macro: ELASTIC_PIPE_FLUSH_EN (adds the flush input).
// Ports:
//   clk       : clock, rising edge
//   res       : synchronous active-low reset
//   en        : global enable, 0 holds the slot
//   flush     : (ELASTIC_PIPE_FLUSH_EN only) clears the valid bit, data holds
//   src_valid : valid of the feeding source (upstream port or previous slot)
//   src_data  : data of the feeding source
//   dst_rdy   : ready of the consuming side (next slot or downstream port)
//   v, d      : current slot contents
//   rdy       : slot can take a new value this cycle
// -----------------------------------------------------------------------------
module elastic_pipe_stage
   import des_pipe_pkg::*;
#(
   parameter int WIDTH = DES_BLOCK_W
) (
   input  logic             clk,
   input  logic             res,
   input  logic             en,
`ifdef ELASTIC_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             src_valid,
   input  logic [0:WIDTH-1] src_data,
   input  logic             dst_rdy,
   output logic             v,
   output logic [0:WIDTH-1] d,
   output logic             rdy
);

   logic             v_r;
   logic [0:WIDTH-1] d_r;
   logic             flush_s;

`ifdef ELASTIC_PIPE_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // An empty slot can always refill; a full one only if its content moves on.
   assign rdy = ~v_r | dst_rdy;
   assign v   = v_r;
   assign d   = d_r;

   // Slot register: reset > flush > enable-gated advance; data only loads valid blocks.
   always_ff @(posedge clk) begin
      if (!res) begin
         v_r <= 1'b0;
         d_r <= {WIDTH{1'b0}};
      end else if (flush_s) begin
         v_r <= 1'b0;
      end else if (en && rdy) begin
         v_r <= src_valid;
         if (src_valid) begin
            d_r <= src_data;
         end else begin
            d_r <= d_r;
         end
      end else begin
         v_r <= v_r;
         d_r <= d_r;
      end
   end

endmodule

// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
// Chain of DEPTH elastic registers with valid/ready flow control, global
// enable and a registered occupancy count. Bubbles are squeezed out when the
// downstream stalls; blocks are never dropped, duplicated or reordered.
// Optional feature macro: ELASTIC_PIPE_FLUSH_EN (adds the flush input, which
// empties the chain in one edge even while en==0).
// Ports:
//   clk   : clock, rising edge
//   res   : synchronous active-low reset
//   en    : global enable, 0 freezes the chain and blocks all transfers
//   flush : (ELASTIC_PIPE_FLUSH_EN only) discard every in-flight block
//   bus   : elastic_pipe_reg_if.slave (in_*, out_*, count)
// Note: in_ready is combinational from out_ready through all stages.
// -----------------------------------------------------------------------------
module elastic_pipe_reg
   import des_pipe_pkg::*;
#(
   parameter int WIDTH = DES_BLOCK_W,
   parameter int DEPTH = DES_ROUNDS
) (
   input  logic                clk,
   input  logic                res,
   input  logic                en,
`ifdef ELASTIC_PIPE_FLUSH_EN
   input  logic                flush,
`endif
   elastic_pipe_reg_if.slave   bus
);

   localparam int CNT_W = cnt_w(DEPTH);

   logic             v_s   [DEPTH];
   logic [0:WIDTH-1] d_s   [DEPTH];
   logic             rdy_s [DEPTH];
   logic             flush_s;
   logic             in_ready_s;
   logic             out_valid_s;
   logic             in_xfer_s;
   logic             out_xfer_s;
   logic [CNT_W-1:0] count_r;

`ifdef ELASTIC_PIPE_FLUSH_EN
   assign flush_s = res & flush;
`else
   assign flush_s = 1'b0;
`endif

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             src_valid_s;
      logic [0:WIDTH-1] src_data_s;
      logic             dst_rdy_s;

      if (i == 0) begin : g_src_port
         assign src_valid_s = bus.in_valid;
         assign src_data_s  = bus.in_data;
      end else begin : g_src_prev
         assign src_valid_s = v_s[i-1];
         assign src_data_s  = d_s[i-1];
      end

      if (i == DEPTH - 1) begin : g_dst_port
         assign dst_rdy_s = bus.out_ready;
      end else begin : g_dst_next
         assign dst_rdy_s = rdy_s[i+1];
      end

      elastic_pipe_stage #(
         .WIDTH     (WIDTH)
      ) u_stage (
         .clk       (clk),
         .res       (res),
         .en        (en),
`ifdef ELASTIC_PIPE_FLUSH_EN
         .flush     (flush),
`endif
         .src_valid (src_valid_s),
         .src_data  (src_data_s),
         .dst_rdy   (dst_rdy_s),
         .v         (v_s[i]),
         .d         (d_s[i]),
         .rdy       (rdy_s[i])
      );
   end

   // A flush cycle blocks both ports so nothing is half-transferred.
   assign in_ready_s  = res & en & rdy_s[0] & ~flush_s;
   assign out_valid_s = en & v_s[DEPTH-1] & ~flush_s;
   assign in_xfer_s   = bus.in_valid & in_ready_s;
   assign out_xfer_s  = out_valid_s & bus.out_ready;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = d_s[DEPTH-1];
   assign bus.count     = count_r;

   // Occupancy tracks port transfers only; internal moves never change it.
   always_ff @(posedge clk) begin
      if (!res) begin
         count_r <= {CNT_W{1'b0}};
      end else if (flush_s) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         count_r <= count_r + CNT_W'(in_xfer_s) - CNT_W'(out_xfer_s);
      end
   end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_reg
// Scoreboard bench for elastic_pipe_reg: a DEPTH=16 instance for the directed
// scenarios and a DEPTH=1 instance for random handshakes. Accepted blocks are
// queued by the drivers; a monitor pops and compares every output transfer.
// Flush scenario is built when ELASTIC_PIPE_FLUSH_EN is defined.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_reg;
   import des_pipe_pkg::*;

   localparam int WA = 64;
   localparam int DA = 16;
   localparam int DB = 1;
   localparam logic [63:0] BASE  = 64'h0123456789ABCDEF;
   localparam logic [63:0] BASE2 = 64'hA000000000000000;
   localparam logic [63:0] BASE3 = 64'hB000000000000000;
   localparam logic [63:0] BASE4 = 64'hC000000000000000;

   logic clk = 1'b0;
   logic res;
   logic en_a, en_b;
   logic flush_a, flush_b;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   first_out_cyc = -1;
   logic [63:0] first_out_data = 64'd0;
   logic [63:0] sb_a[$];
   logic [63:0] sb_b[$];

   elastic_pipe_reg_if #(.WIDTH(WA), .DEPTH(DA)) ifa();
   elastic_pipe_reg_if #(.WIDTH(WA), .DEPTH(DB)) ifb();

   elastic_pipe_reg #(.WIDTH(WA), .DEPTH(DA)) dut_a (
      .clk   (clk),
      .res   (res),
      .en    (en_a),
`ifdef ELASTIC_PIPE_FLUSH_EN
      .flush (flush_a),
`endif
      .bus   (ifa)
   );

   elastic_pipe_reg #(.WIDTH(WA), .DEPTH(DB)) dut_b (
      .clk   (clk),
      .res   (res),
      .en    (en_b),
`ifdef ELASTIC_PIPE_FLUSH_EN
      .flush (flush_b),
`endif
      .bus   (ifb)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step_a(input logic vld, input logic [63:0] dat, input logic ordy,
                         input logic en, input logic fl, output logic acc);
      @(negedge clk);
      ifa.in_valid  = vld;
      ifa.in_data   = dat;
      ifa.out_ready = ordy;
      en_a          = en;
      flush_a       = fl;
      #1;
      acc = vld & (ifa.in_ready === 1'b1);
      if (acc) sb_a.push_back(dat);
   endtask

   task automatic step_b(input logic vld, input logic [63:0] dat, input logic ordy,
                         output logic acc);
      @(negedge clk);
      ifb.in_valid  = vld;
      ifb.in_data   = dat;
      ifb.out_ready = ordy;
      #1;
      chk("b_count_occupancy", 64'(ifb.count), 64'(sb_b.size()));
      acc = vld & (ifb.in_ready === 1'b1);
      if (acc) sb_b.push_back(dat);
   endtask

   task automatic drain_a();
      logic a;
      int   k = 0;
      do begin
         step_a(1'b0, 64'd0, 1'b1, 1'b1, 1'b0, a);
         k++;
      end while ((sb_a.size() != 0 || ifa.count != 5'd0) && k < 200);
      chk("drain_a_pending", 64'(sb_a.size()), 64'd0);
      chk("drain_a_count", 64'(ifa.count), 64'd0);
      chk("drain_a_out_valid", 64'(ifa.out_valid), 64'd0);
   endtask

   // Monitor: compare every output transfer against the scoreboards.
   always @(negedge clk) begin
      #2;
      if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
         if (first_out_cyc < 0) begin
            first_out_cyc  = cyc;
            first_out_data = ifa.out_data;
         end
         if (sb_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_a_extra actual=%h expected=none", ifa.out_data);
         end else begin
            chk("sb_a_data", ifa.out_data, sb_a.pop_front());
         end
      end
      if (ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
         if (sb_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_b_extra actual=%h expected=none", ifb.out_data);
         end else begin
            chk("sb_b_data", ifb.out_data, sb_b.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic acc;
      int   n;
      int   k;
      logic [63:0] c0;

      res = 1'b0; en_a = 1'b1; en_b = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
      ifa.in_valid = 1'b1; ifa.in_data = BASE; ifa.out_ready = 1'b1;
      ifb.in_valid = 1'b0; ifb.in_data = 64'd0; ifb.out_ready = 1'b0;

      // Reset held for two cycles with valid offered.
      for (int i = 0; i < 2; i++) begin
         step_a(1'b1, BASE, 1'b1, 1'b1, 1'b0, acc);
         chk("rst_in_ready", 64'(ifa.in_ready), 64'd0);
         chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
         chk("rst_out_data", ifa.out_data, 64'd0);
         chk("rst_count", 64'(ifa.count), 64'd0);
         chk("rst_b_in_ready", 64'(ifb.in_ready), 64'd0);
      end
      @(negedge clk);
      ifa.in_valid = 1'b0;
      res = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(ifa.in_ready), 64'd1);

      // Continuous stream with downstream always ready.
      first_out_cyc = -1;
      n = 0;
      for (int j = 0; j < 40; j++) begin
         step_a(1'b1, BASE + 64'(j), 1'b1, 1'b1, 1'b0, acc);
         if (j == 0) acc_cyc = cyc + 1;
         if (acc) n++;
         if (j == 20 || j == 30) chk("stream_count", 64'(ifa.count), 64'd16);
      end
      chk("stream_accepted", 64'(n), 64'd40);
      drain_a();
      chk("first_out_latency", 64'(first_out_cyc - acc_cyc), 64'd15);
      chk("first_out_data", first_out_data, BASE);

      // Back-pressure: 20 offered, only 16 fit.
      n = 0;
      for (int j = 0; j < 20; j++) begin
         step_a(1'b1, BASE2 + 64'(n), 1'b0, 1'b1, 1'b0, acc);
         if (acc) n++;
      end
      chk("bp_accepted", 64'(n), 64'd16);
      chk("bp_count", 64'(ifa.count), 64'd16);
      chk("bp_in_ready_full", 64'(ifa.in_ready), 64'd0);
      step_a(1'b1, BASE2 + 64'(n), 1'b1, 1'b1, 1'b0, acc);
      chk("bp_release_in_ready", 64'(acc), 64'd1);
      if (acc) n++;
      step_a(1'b1, BASE2 + 64'(n), 1'b1, 1'b1, 1'b0, acc);
      chk("bp_full_simul_count", 64'(ifa.count), 64'd16);
      if (acc) n++;
      k = 0;
      while (n < 20 && k < 50) begin
         step_a(1'b1, BASE2 + 64'(n), 1'b1, 1'b1, 1'b0, acc);
         if (acc) n++;
         k++;
      end
      chk("bp_total", 64'(n), 64'd20);
      drain_a();

      // Enable dropped for three cycles mid-stream.
      for (int j = 0; j < 10; j++) begin
         step_a(1'b1, BASE3 + 64'(j), 1'b1, 1'b1, 1'b0, acc);
      end
      for (int j = 0; j < 3; j++) begin
         step_a(1'b1, BASE3 + 64'd10, 1'b1, 1'b0, 1'b0, acc);
         if (j == 0) c0 = 64'(ifa.count);
         chk("en_off_in_ready", 64'(acc), 64'd0);
         chk("en_off_out_valid", 64'(ifa.out_valid), 64'd0);
         chk("en_off_count", 64'(ifa.count), 64'd10);
      end
      chk("en_off_frozen", 64'(ifa.count), c0);
      n = 0;
      for (int j = 10; j < 20; j++) begin
         step_a(1'b1, BASE3 + 64'(j), 1'b1, 1'b1, 1'b0, acc);
         if (acc) n++;
      end
      chk("en_resume_accepted", 64'(n), 64'd10);
      drain_a();

`ifdef ELASTIC_PIPE_FLUSH_EN
      // Flush five in-flight blocks; only the next block may come out.
      for (int j = 0; j < 5; j++) begin
         step_a(1'b1, BASE4 + 64'(j), 1'b0, 1'b1, 1'b0, acc);
      end
      chk("pre_flush_count", 64'(ifa.count), 64'd5);
      step_a(1'b1, BASE4 + 64'd5, 1'b1, 1'b1, 1'b1, acc);
      chk("flush_in_ready", 64'(acc), 64'd0);
      chk("flush_out_valid", 64'(ifa.out_valid), 64'd0);
      sb_a.delete();
      step_a(1'b1, BASE4 + 64'd5, 1'b1, 1'b1, 1'b0, acc);
      chk("post_flush_count", 64'(ifa.count), 64'd0);
      chk("post_flush_accept", 64'(acc), 64'd1);
      drain_a();
`endif

      // DEPTH=1 instance under random handshakes.
      ifa.in_valid = 1'b0;
      for (int j = 0; j < 1000; j++) begin
         step_b(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), acc);
      end
      k = 0;
      do begin
         step_b(1'b0, 64'd0, 1'b1, acc);
         k++;
      end while ((sb_b.size() != 0 || ifb.count != 1'b0) && k < 20);
      chk("b_drain_pending", 64'(sb_b.size()), 64'd0);
      chk("b_drain_count", 64'(ifb.count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
